// File: rtl/serial_subtractor.sv
// Bit-serial a - b using one full-subtractor cell and a borrow flop, LSB first.
// Latency: start sampled at edge k, done/diff/borrow visible after edge k+WIDTH.
// Backpressure: start is ignored while busy; a new start in the done cycle chains directly.
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    count;
  logic             br;
  logic             br_nxt;
  logic             ab_x;
  logic             d_bit;
  logic             load;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell on the current operand LSBs plus the stored borrow
  always_comb begin
    ab_x    = a_sr[0] ^ b_sr[0];
    d_bit   = ab_x ^ br;
    br_nxt  = (~a_sr[0] & b_sr[0]) | (~ab_x & br);
    res_nxt = {d_bit, res_sr[WIDTH-1:1]};
    load    = (state != RUN) && start;
    last    = (state == RUN) && (count == LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE/DONE accept start, RUN leaves after the final bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand/result shifting, bit counter, borrow flop and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      count  <= '0;
      br     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      br     <= br_nxt;
      count  <= count + 1'b1;
      // Results only move on the final bit so they stay stable mid-operation
      if (last) begin
        diff   <= res_nxt;
        borrow <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
      end
    end
  end

endmodule
